// File: rtl/microcode_sequencer.sv
// Microcode sequencer: owns the micro-PC, fetches 64-bit microwords from the
// EPROM, and computes the next micro-address from each word's sequencing field.
// Optional return stack for CALL/RETURN is enabled by defining MCSEQ_STACK_EN;
// without it CALL behaves as JUMP, RETURN as NEXT and stk_err stays low.
module microcode_sequencer #(
  parameter logic [7:0] RESET_VEC   = 8'h00,
  parameter int         WAIT_STATES = 0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        _mc_cs,
  output logic        _mc_oe,
  output logic [7:0]  mc_addr,
  input  logic [63:0] mc_data,
  input  logic [7:0]  opcode,
  input  logic [7:0]  cond,
  input  logic        stall,
  input  logic        start,
  output logic [63:0] uinst,
  output logic        uinst_valid,
  output logic [7:0]  upc,
  output logic        halted,
  output logic        stk_err
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALTED} state_t;

  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_CBRANCH  = 3'd2;
  localparam logic [2:0] SEQ_DISPATCH = 3'd3;
  localparam logic [2:0] SEQ_CALL     = 3'd4;
  localparam logic [2:0] SEQ_RETURN   = 3'd5;
  localparam logic [2:0] SEQ_HALT     = 3'd6;
  localparam logic [2:0] WAIT_LAST    = 3'(WAIT_STATES);

  // Reject configurations the wait counter or stack cannot represent.
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
    $error("microcode_sequencer: WAIT_STATES must be 0..7");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("microcode_sequencer: STACK_DEPTH must be at least 1");
  end

  state_t      state_reg, state_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic [7:0]  upc_reg, upc_next;
  logic [63:0] uinst_reg, uinst_next;
  logic        stk_err_reg, stk_err_next;

  // Sequencing fields of the latched microword.
  logic [7:0] target;
  logic [7:0] upc_inc;
  logic [2:0] seq_op;
  logic [2:0] cond_sel;
  logic       cond_inv;
  logic       cond_hit;

  assign target   = uinst_reg[7:0];
  assign seq_op   = uinst_reg[10:8];
  assign cond_sel = uinst_reg[13:11];
  assign cond_inv = uinst_reg[14];
  assign upc_inc  = upc_reg + 8'd1;
  assign cond_hit = cond[cond_sel] ^ cond_inv;

`ifdef MCSEQ_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [7:0]             stack_reg [STACK_DEPTH];
  logic [SP_W-1:0]        sp_reg, sp_next;
  logic [STACK_DEPTH-1:0] push_sel;
  logic [IDX_W-1:0]       top_idx;
  logic                   advance;
  logic                   stack_full;
  logic                   stack_empty;
  logic                   push;
  logic                   pop;
  logic [7:0]             pop_addr;

  assign advance     = (state_reg == ST_EXEC) && !stall;
  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_reg == '0);
  // Overflowing CALLs still jump but their return address is discarded.
  assign push        = advance && (seq_op == SEQ_CALL) && !stack_full;
  assign pop         = advance && (seq_op == SEQ_RETURN) && !stack_empty;
  assign top_idx     = IDX_W'(sp_reg - SP_W'(1));
  assign pop_addr    = stack_reg[top_idx];

  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_push_sel
    assign push_sel[gi] = push && (sp_reg == SP_W'(gi));
  end

  // Write the return address into the slot the stack pointer names.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_sel[i]) stack_reg[i] <= upc_inc;
    end
  end

  // Stack pointer moves up on push, down on pop.
  always_comb begin
    sp_next = sp_reg;
    if (push)     sp_next = sp_reg + SP_W'(1);
    else if (pop) sp_next = sp_reg - SP_W'(1);
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (reset) sp_reg <= '0;
    else       sp_reg <= sp_next;
  end
`endif

  // Next-state, next micro-PC and microword capture.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    upc_next      = upc_reg;
    uinst_next    = uinst_reg;
    stk_err_next  = stk_err_reg;
    case (state_reg)
      ST_FETCH: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          uinst_next    = mc_data;
          wait_cnt_next = '0;
          state_next    = ST_EXEC;
        end else begin
          wait_cnt_next = wait_cnt_reg + 3'd1;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          state_next = ST_FETCH;
          case (seq_op)
            SEQ_JUMP:     upc_next = target;
            SEQ_CBRANCH:  upc_next = cond_hit ? target : upc_inc;
            SEQ_DISPATCH: upc_next = opcode;
            SEQ_CALL: begin
              upc_next = target;
`ifdef MCSEQ_STACK_EN
              if (stack_full) stk_err_next = 1'b1;
`endif
            end
            SEQ_RETURN: begin
`ifdef MCSEQ_STACK_EN
              if (stack_empty) begin
                upc_next     = RESET_VEC;
                stk_err_next = 1'b1;
              end else begin
                upc_next = pop_addr;
              end
`else
              upc_next = upc_inc;
`endif
            end
            SEQ_HALT: begin
              upc_next   = upc_inc;
              state_next = ST_HALTED;
            end
            default:      upc_next = upc_inc;
          endcase
        end
      end
      ST_HALTED: begin
        if (start) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
      upc_reg      <= RESET_VEC;
      uinst_reg    <= '0;
      stk_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      upc_reg      <= upc_next;
      uinst_reg    <= uinst_next;
      stk_err_reg  <= stk_err_next;
    end
  end

  // EPROM is only selected while fetching, and never during a reset cycle.
  assign _mc_cs      = reset || (state_reg != ST_FETCH);
  assign _mc_oe      = reset || (state_reg != ST_FETCH);
  assign mc_addr     = upc_reg;
  assign uinst       = uinst_reg;
  assign uinst_valid = (state_reg == ST_EXEC);
  assign upc         = upc_reg;
  assign halted      = (state_reg == ST_HALTED);
  assign stk_err     = stk_err_reg;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus a
// randomized program run against a transaction-level reference model.
module tb_microcode_sequencer;

  localparam int         WS    = 2;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RVEC  = 8'h00;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_CBRANCH  = 3'd2;
  localparam logic [2:0] OP_DISPATCH = 3'd3;
  localparam logic [2:0] OP_CALL     = 3'd4;
  localparam logic [2:0] OP_RETURN   = 3'd5;
  localparam logic [2:0] OP_HALT     = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WAIT_STATES=2)
  logic        reset = 1'b1, stall = 1'b0, start = 1'b0;
  logic [7:0]  opcode = 8'h00, cond = 8'h00;
  logic        _mc_cs, _mc_oe, uinst_valid, halted, stk_err;
  logic [7:0]  mc_addr, upc;
  logic [63:0] mc_data, uinst;

  // Second DUT (WAIT_STATES=0) for the zero-wait fetch timing
  logic        reset0 = 1'b1, stall0 = 1'b0, start0 = 1'b0;
  logic        cs0, oe0, valid0, halted0, stk_err0;
  logic [7:0]  addr0, upc0;
  logic [63:0] data0, uinst0;

  logic [63:0] rom [256];
  assign mc_data = rom[mc_addr];
  assign data0   = rom[addr0];

  microcode_sequencer #(.RESET_VEC(RVEC), .WAIT_STATES(WS), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), ._mc_cs(_mc_cs), ._mc_oe(_mc_oe), .mc_addr(mc_addr),
    .mc_data(mc_data), .opcode(opcode), .cond(cond), .stall(stall), .start(start),
    .uinst(uinst), .uinst_valid(uinst_valid), .upc(upc), .halted(halted), .stk_err(stk_err)
  );

  microcode_sequencer #(.RESET_VEC(RVEC), .WAIT_STATES(0), .STACK_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset0), ._mc_cs(cs0), ._mc_oe(oe0), .mc_addr(addr0),
    .mc_data(data0), .opcode(opcode), .cond(cond), .stall(stall0), .start(start0),
    .uinst(uinst0), .uinst_valid(valid0), .upc(upc0), .halted(halted0), .stk_err(stk_err0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: micro-PC, return stack, sticky error.
  logic [7:0] m_upc;
  logic [7:0] m_stack [$];
  logic       m_err;

  function automatic logic [63:0] mkw(input logic [2:0] op, input logic [7:0] tgt,
                                      input logic [2:0] sel, input logic inv);
    mkw = {32'hC0DE_F00D, 17'h0, inv, sel, op, tgt};
  endfunction

  // Apply one executed microword to the model.
  task automatic model_exec(input logic [63:0] w, input logic [7:0] c,
                            input logic [7:0] op, output bit halt);
    logic [7:0] nxt;
    nxt  = m_upc + 8'd1;
    halt = 0;
    case (w[10:8])
      OP_JUMP:     m_upc = w[7:0];
      OP_CBRANCH:  m_upc = (c[w[13:11]] ^ w[14]) ? w[7:0] : nxt;
      OP_DISPATCH: m_upc = op;
      OP_CALL: begin
`ifdef MCSEQ_STACK_EN
        if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
        else m_err = 1'b1;
`endif
        m_upc = w[7:0];
      end
      OP_RETURN: begin
`ifdef MCSEQ_STACK_EN
        if (m_stack.size() == 0) begin
          m_upc = RVEC;
          m_err = 1'b1;
        end else begin
          m_upc = m_stack.pop_back();
        end
`else
        m_upc = nxt;
`endif
      end
      OP_HALT: begin
        m_upc = nxt;
        halt  = 1;
      end
      default: m_upc = nxt;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (_mc_cs !== 1'b1 || _mc_oe !== 1'b1) begin
      errors++;
      $display("FAIL reset_cycle_cs: cs=%b oe=%b, required 1 1", _mc_cs, _mc_oe);
    end
    @(negedge clk);
    #1;
    checks++;
    if (upc !== RVEC || uinst !== 64'h0 || uinst_valid !== 1'b0 || halted !== 1'b0 ||
        stk_err !== 1'b0 || _mc_cs !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: upc=%h uinst=%h valid=%b halted=%b stk_err=%b cs=%b, required %h 0 0 0 0 1",
               upc, uinst, uinst_valid, halted, stk_err, _mc_cs, RVEC);
    end
    m_upc = RVEC;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // One microinstruction: fetch phase, EXEC (with nstall held cycles), and HALTED if it halts.
  task automatic do_instr(input int nstall, input bit rnd, input logic [7:0] c_dir,
                          input logic [7:0] op_dir);
    logic [63:0] w;
    bit          h;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clk);
      reset = 1'b0; stall = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      cond = 8'($urandom); opcode = 8'($urandom);
      #1;
      checks++;
      if (_mc_cs !== 1'b0 || _mc_oe !== 1'b0 || mc_addr !== m_upc || uinst_valid !== 1'b0 ||
          halted !== 1'b0) begin
        errors++;
        $display("FAIL fetch[%0d]: cs=%b oe=%b addr=%h valid=%b halted=%b, required 0 0 %h 0 0",
                 k, _mc_cs, _mc_oe, mc_addr, uinst_valid, halted, m_upc);
      end
    end
    w = rom[m_upc];
    for (int k = 0; k <= nstall; k++) begin
      @(negedge clk);
      stall  = (k < nstall);
      start  = 1'($urandom_range(0, 1));
      cond   = rnd ? 8'($urandom) : c_dir;
      opcode = rnd ? 8'($urandom) : op_dir;
      #1;
      checks++;
      if (uinst_valid !== 1'b1 || _mc_cs !== 1'b1 || _mc_oe !== 1'b1 || uinst !== w ||
          upc !== m_upc || stk_err !== m_err) begin
        errors++;
        $display("FAIL exec[%0d]: valid=%b cs=%b oe=%b uinst=%h upc=%h stk_err=%b, required 1 1 1 %h %h %b",
                 k, uinst_valid, _mc_cs, _mc_oe, uinst, upc, stk_err, w, m_upc, m_err);
      end
    end
    model_exec(w, cond, opcode, h);
    if (h) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start = (k == 3); stall = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (halted !== 1'b1 || _mc_cs !== 1'b1 || _mc_oe !== 1'b1 || uinst_valid !== 1'b0 ||
            upc !== m_upc) begin
          errors++;
          $display("FAIL halted[%0d]: halted=%b cs=%b oe=%b valid=%b upc=%h, required 1 1 1 0 %h",
                   k, halted, _mc_cs, _mc_oe, uinst_valid, upc, m_upc);
        end
      end
    end
    $display("instr done: next upc=%h halt=%0d stalls=%0d", m_upc, h, nstall);
  endtask

  task automatic test_reset();
    rom[0] = mkw(OP_NEXT, 8'h77, 3'd0, 1'b0);
    rom[1] = mkw(OP_NEXT, 8'h12, 3'd0, 1'b0);
    do_reset();
    @(negedge clk); reset0 = 1'b0; #1;
    checks++;
    if (cs0 !== 1'b0 || oe0 !== 1'b0 || addr0 !== 8'h00 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL ws0_fetch0: cs=%b oe=%b addr=%h valid=%b, required 0 0 00 0", cs0, oe0, addr0, valid0);
    end
    @(negedge clk); #1;
    checks++;
    if (cs0 !== 1'b1 || valid0 !== 1'b1 || uinst0 !== rom[0]) begin
      errors++;
      $display("FAIL ws0_exec0: cs=%b valid=%b uinst=%h, required 1 1 %h", cs0, valid0, uinst0, rom[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (cs0 !== 1'b0 || addr0 !== 8'h01 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL ws0_fetch1: cs=%b addr=%h valid=%b, required 0 01 0", cs0, addr0, valid0);
    end
    reset0 = 1'b1;
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int i = 0; i < 4; i++) do_instr(0, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (upc !== 8'h04) begin
      errors++;
      $display("FAIL ws2_seq: upc=%h, required 04", upc);
    end
  endtask

  task automatic test_cbranch();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c;
      logic [7:0] exp;
      c    = 8'($urandom);
      c[3] = i[0];
      exp  = (i[0] ^ i[1]) ? 8'h40 : 8'h21;
      do_reset();
      rom[8'h00] = mkw(OP_JUMP, 8'h20, 3'd0, 1'b0);
      rom[8'h20] = mkw(OP_CBRANCH, 8'h40, 3'd3, i[1]);
      do_instr(0, 1, 8'h00, 8'h00);
      do_instr(0, 0, c, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (upc !== exp) begin
        errors++;
        $display("FAIL cbranch c3=%0d inv=%0d: upc=%h, required %h", i[0], i[1], upc, exp);
      end
    end
  endtask

  task automatic test_dispatch_stall();
    do_reset();
    rom[8'h00] = mkw(OP_DISPATCH, 8'h33, 3'd0, 1'b0);
    rom[8'hA5] = mkw(OP_NEXT, 8'h00, 3'd0, 1'b0);
    do_instr(5, 0, 8'($urandom), 8'hA5);
    @(posedge clk); #1;
    checks++;
    if (upc !== 8'hA5 || mc_addr !== 8'hA5 || _mc_cs !== 1'b0) begin
      errors++;
      $display("FAIL dispatch: upc=%h addr=%h cs=%b, required a5 a5 0", upc, mc_addr, _mc_cs);
    end
    do_instr(0, 1, 8'h00, 8'h00);
  endtask

  task automatic test_wrap_halt();
    do_reset();
    rom[8'h00] = mkw(OP_JUMP, 8'hFF, 3'd0, 1'b0);
    rom[8'hFF] = mkw(OP_NEXT, 8'h00, 3'd0, 1'b0);
    do_instr(0, 1, 8'h00, 8'h00);
    do_instr(1, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (upc !== 8'h00) begin
      errors++;
      $display("FAIL wrap: upc=%h, required 00", upc);
    end
    rom[8'h00] = mkw(OP_JUMP, 8'h10, 3'd0, 1'b0);
    rom[8'h10] = mkw(OP_HALT, 8'h00, 3'd0, 1'b0);
    rom[8'h11] = mkw(OP_NEXT, 8'h00, 3'd0, 1'b0);
    do_instr(0, 1, 8'h00, 8'h00);
    do_instr(0, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (_mc_cs !== 1'b0 || mc_addr !== 8'h11 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume: cs=%b addr=%h halted=%b, required 0 11 0", _mc_cs, mc_addr, halted);
    end
    do_instr(0, 1, 8'h00, 8'h00);
  endtask

  task automatic test_stack();
`ifdef MCSEQ_STACK_EN
    do_reset();
    rom[8'h00] = mkw(OP_CALL, 8'h10, 3'd0, 1'b0);
    rom[8'h10] = mkw(OP_CALL, 8'h20, 3'd0, 1'b0);
    rom[8'h20] = mkw(OP_CALL, 8'h30, 3'd0, 1'b0);
    rom[8'h30] = mkw(OP_CALL, 8'h40, 3'd0, 1'b0);
    rom[8'h40] = mkw(OP_CALL, 8'h50, 3'd0, 1'b0);
    rom[8'h50] = mkw(OP_RETURN, 8'h00, 3'd0, 1'b0);
    rom[8'h31] = mkw(OP_RETURN, 8'h00, 3'd0, 1'b0);
    rom[8'h21] = mkw(OP_RETURN, 8'h00, 3'd0, 1'b0);
    rom[8'h11] = mkw(OP_RETURN, 8'h00, 3'd0, 1'b0);
    rom[8'h01] = mkw(OP_RETURN, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) do_instr(0, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (stk_err !== 1'b1 || upc !== 8'h50) begin
      errors++;
      $display("FAIL stack_overflow: stk_err=%b upc=%h, required 1 50", stk_err, upc);
    end
    for (int i = 0; i < 5; i++) do_instr(0, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (upc !== RVEC || stk_err !== 1'b1) begin
      errors++;
      $display("FAIL stack_underflow: upc=%h stk_err=%b, required %h 1", upc, stk_err, RVEC);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    rom[8'h00] = mkw(OP_JUMP, 8'h80, 3'd0, 1'b0);
    do_instr(0, 1, 8'h00, 8'h00);
    @(negedge clk); reset = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (_mc_cs !== 1'b0 || mc_addr !== 8'h80) begin
      errors++;
      $display("FAIL mid_fetch_pre: cs=%b addr=%h, required 0 80", _mc_cs, mc_addr);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) rom[i] = {32'($urandom), 32'($urandom)};
    do_reset();
    for (int n = 0; n < 250; n++) do_instr($urandom_range(0, 2), 1, 8'h00, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mkw(OP_NEXT, 8'h00, 3'd0, 1'b0);
    m_upc = RVEC;
    m_err = 1'b0;
    test_reset();
    test_wait_states();
    test_cbranch();
    test_dispatch_stall();
    test_wrap_halt();
    test_stack();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
